// File: rtl/btn_pkg.sv
// Shared definitions for the four-channel button conditioner: channel count and debounce FSM states.
package btn_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: level, press/release pulses, optional long-press pulse.
// Long-press detection is compiled in only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    import btn_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("btn_debounce_ch: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 2");
    end

    btn_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next, press_next, release_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            level         <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // A level change needs the opposite input seen on DEBOUNCE_CYCLES+1 consecutive edges.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = level;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = DEB_PRESS;
                    cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = '0;
                end
            end
            DEB_RELEASE: begin
                if (s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

    logic             holding;
    logic [LONG_W-1:0] long_cnt;

    assign holding = (state == PRESSED) || (state == DEB_RELEASE);

    // Counter parks at LONG_CYCLES so the pulse fires once per hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= holding && (long_cnt == LONG_LAST);
            if (!holding) begin
                long_cnt <= '0;
            end else if (long_cnt != LONG_MAX) begin
                long_cnt <= long_cnt + 1'b1;
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: invert active-low inputs, 2-flop synchronize, debounce per channel.
// Define BTN_LONG_PRESS_EN to enable btn_long; otherwise btn_long is tied to 0.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 200_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] button,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    logic [NUM_BTN-1:0] sync_p0, sync_p1;

    // Synchronizer: only sync_p1 feeds the channel FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= ~button;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .s            (sync_p1[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .long_pulse   (btn_long[i])
        );
    end

endmodule
